// File: rtl/dram_pair_arbiter.sv
// Round-robin arbiter sharing the DRAM k/l pair request path, with in-order tag routing of responses.
// Optional build macro ARB_PRIO0_EN: requester 0 gets strict priority over the round-robin group.
module dram_pair_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ADDR_W  = 58,
  parameter int MAX_OUT = 8
) (
  input  logic                      CLK_200M,
  input  logic                      reset_n,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_k,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_l,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fifo_wr_en,
  output logic [ADDR_W-1:0]         fifo_addr_1,
  output logic [ADDR_W-1:0]         fifo_addr_2,
  input  logic                      rsp_both_valid,
  input  logic [511:0]              rsp_k_data,
  input  logic [511:0]              rsp_l_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [511:0]              rsp_k_out,
  output logic [511:0]              rsp_l_out,
  output logic [ID_W+1:0]           outstanding,
  output logic                      err_orphan
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = ID_W + 2;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    next_ptr;
  logic [ID_W-1:0]    tag_q [MAX_OUT];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [NUM_REQ-1:0] rr_valid;
  logic [ID_W-1:0]    grant_id;
  logic               grant_vld;
  logic               grant_ok;
  logic               push;
  logic               pop;

  // The credit count doubles as the tag queue occupancy, so the queue can never overflow.
  always_comb begin
    int idx;
    logic [ID_W-1:0] sel;
    idx       = 0;
    sel       = '0;
    grant_vld = 1'b0;
    grant_id  = '0;
    grant_ok  = reset_n && !stall && (count < CNT_W'(MAX_OUT));
    rr_valid  = req_valid;
`ifdef ARB_PRIO0_EN
    rr_valid[0] = 1'b0;
`endif
    // Scan from the farthest offset back to rr_ptr so the nearest valid requester wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (rr_valid[sel]) begin
        grant_vld = 1'b1;
        grant_id  = sel;
      end
    end
`ifdef ARB_PRIO0_EN
    if (req_valid[0]) begin
      grant_vld = 1'b1;
      grant_id  = '0;
    end
`endif
    req_ready = '0;
    if (grant_ok && grant_vld) req_ready[grant_id] = 1'b1;
    push     = grant_ok && grant_vld;
    pop      = rsp_both_valid && (count != '0);
    next_ptr = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge CLK_200M) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fifo_wr_en  <= 1'b0;
      fifo_addr_1 <= '0;
      fifo_addr_2 <= '0;
      rsp_valid   <= '0;
      rsp_k_out   <= '0;
      rsp_l_out   <= '0;
      err_orphan  <= 1'b0;
    end else begin
      fifo_wr_en <= push;
      if (push) begin
        fifo_addr_1 <= req_addr_k[grant_id*ADDR_W +: ADDR_W];
        fifo_addr_2 <= req_addr_l[grant_id*ADDR_W +: ADDR_W];
        wr_ptr      <= wr_ptr + 1'b1;
      end
`ifdef ARB_PRIO0_EN
      if (push && grant_id != '0) rr_ptr <= next_ptr;
`else
      if (push) rr_ptr <= next_ptr;
`endif
      rsp_valid <= '0;
      if (pop) begin
        rsp_valid[tag_q[rd_ptr]] <= 1'b1;
        rsp_k_out                <= rsp_k_data;
        rsp_l_out                <= rsp_l_data;
        rd_ptr                   <= rd_ptr + 1'b1;
      end else if (rsp_both_valid) begin
        err_orphan <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage needs no reset; entries are only read behind a nonzero count.
  always_ff @(posedge CLK_200M) begin
    if (reset_n && push) tag_q[wr_ptr] <= grant_id;
  end

  assign outstanding = count;

endmodule

// File: tb/tb_dram_pair_arbiter.sv
// Self-checking bench for dram_pair_arbiter: directed scenarios plus randomized traffic against a queue-based model.
// Build with ARB_PRIO0_EN defined to exercise the strict-priority variant.
module tb_dram_pair_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int ADDR_W  = 58;
  localparam int MAX_OUT = 8;

  logic                      CLK_200M = 1'b0;
  logic                      reset_n;
  logic                      stall;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_k;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_l;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_wr_en;
  logic [ADDR_W-1:0]         fifo_addr_1;
  logic [ADDR_W-1:0]         fifo_addr_2;
  logic                      rsp_both_valid;
  logic [511:0]              rsp_k_data;
  logic [511:0]              rsp_l_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [511:0]              rsp_k_out;
  logic [511:0]              rsp_l_out;
  logic [ID_W+1:0]           outstanding;
  logic                      err_orphan;

  int checks   = 0;
  int failures = 0;

  // Reference model state: arbitration pointer, queue of issued ids, expected registered outputs.
  int                 m_rr;
  int                 m_q[$];
  logic               m_wr;
  logic [ADDR_W-1:0]  m_a1, m_a2;
  logic [NUM_REQ-1:0] m_rv;
  logic [511:0]       m_k, m_l;
  logic               m_err;

  always #5 CLK_200M = ~CLK_200M;

  dram_pair_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
    .CLK_200M(CLK_200M), .reset_n(reset_n), .stall(stall), .req_valid(req_valid),
    .req_addr_k(req_addr_k), .req_addr_l(req_addr_l), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_addr_1(fifo_addr_1), .fifo_addr_2(fifo_addr_2),
    .rsp_both_valid(rsp_both_valid), .rsp_k_data(rsp_k_data), .rsp_l_data(rsp_l_data),
    .rsp_valid(rsp_valid), .rsp_k_out(rsp_k_out), .rsp_l_out(rsp_l_out),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  function automatic int model_grant();
    if (!reset_n || stall || m_q.size() >= MAX_OUT) return -1;
`ifdef ARB_PRIO0_EN
    if (req_valid[0]) return 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int c;
      c = (m_rr + i) % NUM_REQ;
      if (c != 0 && req_valid[c[ID_W-1:0]]) return c;
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      int c;
      c = (m_rr + i) % NUM_REQ;
      if (req_valid[c[ID_W-1:0]]) return c;
    end
`endif
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] exp_ready();
    int g;
    g = model_grant();
    return (g < 0) ? '0 : NUM_REQ'(1) << g;
  endfunction

  task automatic model_clock();
    int g;
    g = model_grant();
    if (!reset_n) begin
      m_rr = 0; m_q.delete(); m_wr = 0; m_a1 = '0; m_a2 = '0;
      m_rv = '0; m_k = '0; m_l = '0; m_err = 0;
      return;
    end
    m_rv = '0;
    if (rsp_both_valid) begin
      if (m_q.size() > 0) begin
        int h;
        h = m_q.pop_front();
        m_rv[h[ID_W-1:0]] = 1'b1;
        m_k = rsp_k_data;
        m_l = rsp_l_data;
      end else begin
        m_err = 1'b1;
      end
    end
    m_wr = (g >= 0);
    if (g >= 0) begin
      m_a1 = req_addr_k[g*ADDR_W +: ADDR_W];
      m_a2 = req_addr_l[g*ADDR_W +: ADDR_W];
      m_q.push_back(g);
`ifdef ARB_PRIO0_EN
      if (g != 0) m_rr = (g + 1) % NUM_REQ;
`else
      m_rr = (g + 1) % NUM_REQ;
`endif
    end
  endtask

  task automatic apply_stimulus(input logic rst_n, input logic st, input logic [NUM_REQ-1:0] v,
                                input logic rsp);
    @(negedge CLK_200M);
    reset_n        = rst_n;
    stall          = st;
    req_valid      = v;
    rsp_both_valid = rsp;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr_k[i*ADDR_W +: ADDR_W] = ADDR_W'({$urandom(), $urandom()});
      req_addr_l[i*ADDR_W +: ADDR_W] = ADDR_W'({$urandom(), $urandom()});
    end
    for (int j = 0; j < 16; j++) begin
      rsp_k_data[j*32 +: 32] = $urandom();
      rsp_l_data[j*32 +: 32] = $urandom();
    end
    #1;
  endtask

  task automatic tick();
    @(posedge CLK_200M);
    model_clock();
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 1'b0, '0, 1'b0); tick();
    apply_stimulus(1'b0, 1'b0, '0, 1'b0); tick();
  endtask

  task automatic test_reset();
    apply_stimulus(1'b0, 1'b0, '0, 1'b1); tick();
    apply_stimulus(1'b0, 1'b0, '1, 1'b1);
    checks++; if (req_ready !== '0) begin failures++; $display("[TB] FAIL reset_ready got=%0h exp=0", req_ready); end
    checks++; if (outstanding !== '0) begin failures++; $display("[TB] FAIL reset_outstanding got=%0d exp=0", outstanding); end
    checks++; if (fifo_wr_en !== 1'b0 || fifo_addr_1 !== '0 || fifo_addr_2 !== '0) begin failures++; $display("[TB] FAIL reset_fifo got=%0b/%0h/%0h exp=0", fifo_wr_en, fifo_addr_1, fifo_addr_2); end
    checks++; if (rsp_valid !== '0 || rsp_k_out !== '0 || rsp_l_out !== '0) begin failures++; $display("[TB] FAIL reset_rsp got=%0h exp=0", rsp_valid); end
    checks++; if (err_orphan !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%0b exp=0", err_orphan); end
    tick();
  endtask

  task automatic test_round_robin();
    int pulses;
    pulses = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      logic [NUM_REQ-1:0] exp;
      exp = (c < 8) ? NUM_REQ'(1) << (c % NUM_REQ) : '0;
      apply_stimulus(1'b1, 1'b0, 4'b1111, 1'b0);
      if (fifo_wr_en === 1'b1) pulses++;
      checks++; if (req_ready !== exp) begin failures++; $display("[TB] FAIL rr_grant c=%0d got=%0h exp=%0h", c, req_ready, exp); end
      checks++; if (outstanding !== 4'((c < 8) ? c : 8)) begin failures++; $display("[TB] FAIL rr_outstanding c=%0d got=%0d exp=%0d", c, outstanding, (c < 8) ? c : 8); end
      checks++; if (fifo_wr_en !== (c >= 1 && c <= 8)) begin failures++; $display("[TB] FAIL rr_wr_en c=%0d got=%0b", c, fifo_wr_en); end
      checks++; if (fifo_addr_1 !== m_a1 || fifo_addr_2 !== m_a2) begin failures++; $display("[TB] FAIL rr_addr c=%0d got=%0h/%0h exp=%0h/%0h", c, fifo_addr_1, fifo_addr_2, m_a1, m_a2); end
      tick();
    end
    checks++; if (pulses != 8) begin failures++; $display("[TB] FAIL rr_pulses got=%0d exp=8", pulses); end
    for (int d = 0; d < 9; d++) begin
      apply_stimulus(1'b1, 1'b0, '0, d < 8);
      checks++; if (rsp_valid !== m_rv) begin failures++; $display("[TB] FAIL drain_rsp_valid d=%0d got=%0h exp=%0h", d, rsp_valid, m_rv); end
      checks++; if (rsp_k_out !== m_k || rsp_l_out !== m_l) begin failures++; $display("[TB] FAIL drain_data d=%0d got=%0h exp=%0h", d, rsp_k_out, m_k); end
      tick();
    end
    checks++; if (outstanding !== '0 || err_orphan !== 1'b0) begin failures++; $display("[TB] FAIL drain_end got=%0d/%0b exp=0/0", outstanding, err_orphan); end
  endtask

  task automatic test_single_pair();
    logic [511:0] sk, sl;
    do_reset();
    apply_stimulus(1'b1, 1'b0, 4'b0100, 1'b0);
    req_addr_k[2*ADDR_W +: ADDR_W] = ADDR_W'(58'h100);
    req_addr_l[2*ADDR_W +: ADDR_W] = ADDR_W'(58'h1A0);
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("[TB] FAIL single_ready got=%0h exp=4", req_ready); end
    tick();
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    checks++; if (fifo_wr_en !== 1'b1 || fifo_addr_1 !== 58'h100 || fifo_addr_2 !== 58'h1A0) begin failures++; $display("[TB] FAIL single_fifo got=%0b/%0h/%0h exp=1/100/1a0", fifo_wr_en, fifo_addr_1, fifo_addr_2); end
    tick();
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    sk = rsp_k_data;
    sl = rsp_l_data;
    checks++; if (fifo_wr_en !== 1'b0 || rsp_valid !== '0) begin failures++; $display("[TB] FAIL single_idle got=%0b/%0h exp=0/0", fifo_wr_en, rsp_valid); end
    tick();
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    checks++; if (rsp_valid !== 4'b0100) begin failures++; $display("[TB] FAIL single_rsp_valid got=%0h exp=4", rsp_valid); end
    checks++; if (rsp_k_out !== sk || rsp_l_out !== sl) begin failures++; $display("[TB] FAIL single_rsp_data got=%0h exp=%0h", rsp_k_out, sk); end
    checks++; if (outstanding !== '0) begin failures++; $display("[TB] FAIL single_outstanding got=%0d exp=0", outstanding); end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      apply_stimulus(1'b1, 1'b1, 4'b0011, 1'b0);
      checks++; if (req_ready !== '0 || fifo_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL stall_block c=%0d got=%0h/%0b exp=0/0", c, req_ready, fifo_wr_en); end
      tick();
    end
    apply_stimulus(1'b1, 1'b0, 4'b0011, 1'b0);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL stall_first got=%0h exp=1", req_ready); end
    tick();
    apply_stimulus(1'b1, 1'b0, 4'b0011, 1'b0);
    checks++; if (req_ready !== 4'b0010 || fifo_wr_en !== 1'b1) begin failures++; $display("[TB] FAIL stall_second got=%0h/%0b exp=2/1", req_ready, fifo_wr_en); end
    tick();
  endtask

  task automatic test_credit();
    do_reset();
    repeat (8) begin apply_stimulus(1'b1, 1'b0, 4'b1111, 1'b0); tick(); end
    apply_stimulus(1'b1, 1'b0, 4'b1111, 1'b1);
    checks++; if (outstanding !== 4'd8 || req_ready !== '0) begin failures++; $display("[TB] FAIL credit_full got=%0d/%0h exp=8/0", outstanding, req_ready); end
    tick();
    apply_stimulus(1'b1, 1'b0, 4'b1111, 1'b0);
    checks++; if (outstanding !== 4'd7 || req_ready !== 4'b0001 || rsp_valid !== 4'b0001) begin failures++; $display("[TB] FAIL credit_resume got=%0d/%0h/%0h exp=7/1/1", outstanding, req_ready, rsp_valid); end
    tick();
    apply_stimulus(1'b1, 1'b0, 4'b1111, 1'b1);
    checks++; if (outstanding !== 4'd8 || req_ready !== '0) begin failures++; $display("[TB] FAIL credit_refull got=%0d/%0h exp=8/0", outstanding, req_ready); end
    tick();
    apply_stimulus(1'b1, 1'b0, 4'b1111, 1'b1);
    checks++; if (outstanding !== 4'd7 || req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL credit_seven got=%0d/%0h exp=7/2", outstanding, req_ready); end
    tick();
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    checks++; if (outstanding !== 4'd7 || rsp_valid !== 4'b0100 || fifo_wr_en !== 1'b1) begin failures++; $display("[TB] FAIL credit_same_cycle got=%0d/%0h/%0b exp=7/4/1", outstanding, rsp_valid, fifo_wr_en); end
    checks++; if (fifo_addr_1 !== m_a1 || fifo_addr_2 !== m_a2) begin failures++; $display("[TB] FAIL credit_addr got=%0h exp=%0h", fifo_addr_1, m_a1); end
    tick();
  endtask

  task automatic test_orphan();
    do_reset();
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    checks++; if (err_orphan !== 1'b0) begin failures++; $display("[TB] FAIL orphan_pre got=%0b exp=0", err_orphan); end
    tick();
    for (int c = 0; c < 3; c++) begin
      apply_stimulus(1'b1, 1'b0, '0, 1'b0);
      checks++; if (err_orphan !== 1'b1 || rsp_valid !== '0) begin failures++; $display("[TB] FAIL orphan_sticky c=%0d got=%0b/%0h exp=1/0", c, err_orphan, rsp_valid); end
      tick();
    end
    do_reset();
    repeat (3) begin apply_stimulus(1'b1, 1'b0, 4'b1111, 1'b0); tick(); end
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    checks++; if (outstanding !== 4'd3) begin failures++; $display("[TB] FAIL burst_count got=%0d exp=3", outstanding); end
    tick();
    apply_stimulus(1'b0, 1'b0, '0, 1'b0); tick();
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    checks++; if (outstanding !== '0 || err_orphan !== 1'b0) begin failures++; $display("[TB] FAIL burst_reset got=%0d/%0b exp=0/0", outstanding, err_orphan); end
    tick();
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    checks++; if (err_orphan !== 1'b1 || rsp_valid !== '0) begin failures++; $display("[TB] FAIL burst_orphan got=%0b/%0h exp=1/0", err_orphan, rsp_valid); end
    tick();
  endtask

`ifdef ARB_PRIO0_EN
  task automatic test_prio0();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      apply_stimulus(1'b1, 1'b0, 4'b1011, c > 0);
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL prio0_grant c=%0d got=%0h exp=1", c, req_ready); end
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      logic [NUM_REQ-1:0] exp;
      exp = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      apply_stimulus(1'b1, 1'b0, 4'b1010, 1'b1);
      checks++; if (req_ready !== exp) begin failures++; $display("[TB] FAIL prio0_alt c=%0d got=%0h exp=%0h", c, req_ready, exp); end
      tick();
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      apply_stimulus(($urandom % 100) != 0, ($urandom % 4) == 0, NUM_REQ'($urandom),
                     (m_q.size() > 0) ? (($urandom % 3) == 0) : (($urandom % 40) == 0));
      checks++; if (req_ready !== exp_ready()) begin failures++; $display("[TB] FAIL rand_ready c=%0d got=%0h exp=%0h", c, req_ready, exp_ready()); end
      checks++; if (fifo_wr_en !== m_wr || fifo_addr_1 !== m_a1 || fifo_addr_2 !== m_a2) begin failures++; $display("[TB] FAIL rand_fifo c=%0d got=%0b/%0h/%0h exp=%0b/%0h/%0h", c, fifo_wr_en, fifo_addr_1, fifo_addr_2, m_wr, m_a1, m_a2); end
      checks++; if (rsp_valid !== m_rv) begin failures++; $display("[TB] FAIL rand_rsp_valid c=%0d got=%0h exp=%0h", c, rsp_valid, m_rv); end
      checks++; if (rsp_k_out !== m_k || rsp_l_out !== m_l) begin failures++; $display("[TB] FAIL rand_rsp_data c=%0d got=%0h exp=%0h", c, rsp_k_out, m_k); end
      checks++; if (outstanding !== 4'(m_q.size()) || err_orphan !== m_err) begin failures++; $display("[TB] FAIL rand_state c=%0d got=%0d/%0b exp=%0d/%0b", c, outstanding, err_orphan, m_q.size(), m_err); end
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; req_valid = '0; rsp_both_valid = 1'b0;
    req_addr_k = '0; req_addr_l = '0; rsp_k_data = '0; rsp_l_data = '0;
    m_rr = 0; m_wr = 0; m_a1 = '0; m_a2 = '0; m_rv = '0; m_k = '0; m_l = '0; m_err = 0;
    test_reset();
    test_single_pair();
    test_orphan();
`ifdef ARB_PRIO0_EN
    test_prio0();
`else
    test_round_robin();
    test_stall();
    test_credit();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
